// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - cache miss initiator: optional dirty-line writeback, then optional line refill
// Optional per-phase wait timeout with error response: define MEM_REQ_TIMEOUT_EN.
module mem_request_unit #(
  parameter int ADDRESS_SIZE    = 12,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_writeback,
  input  logic                       req_fill,
  input  logic [ADDRESS_SIZE-1:0]    req_wb_addr,
  input  logic [CACHE_LINE_SIZE-1:0] req_wb_data,
  input  logic [ADDRESS_SIZE-1:0]    req_fill_addr,
  output logic                       resp_valid,
  output logic [CACHE_LINE_SIZE-1:0] resp_data,
  output logic                       resp_error,
  output logic                       mem_write_enable,
  output logic                       mem_read_enable,
  output logic [ADDRESS_SIZE-1:0]    mem_address,
  output logic [CACHE_LINE_SIZE-1:0] mem_data_in,
  input  logic [CACHE_LINE_SIZE-1:0] mem_data_out,
  input  logic                       mem_data_ready
);

  localparam int OFFSET_BITS = $clog2(CACHE_LINE_SIZE / 8);
  localparam logic [ADDRESS_SIZE-1:0] LINE_MASK = ~(ADDRESS_SIZE'((1 << OFFSET_BITS) - 1));

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_RESP} state_t;

  state_t                     state_q, state_d;
  logic                       fill_q, fill_d;
  logic [ADDRESS_SIZE-1:0]    fill_addr_q, fill_addr_d;
  logic                       mem_we_q, mem_we_d;
  logic                       mem_re_q, mem_re_d;
  logic [ADDRESS_SIZE-1:0]    mem_addr_q, mem_addr_d;
  logic [CACHE_LINE_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [CACHE_LINE_SIZE-1:0] resp_data_q, resp_data_d;
  logic                       resp_valid_q, resp_valid_d;
  logic                       phase_timeout;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             resp_error_q, resp_error_d;
`else
  logic             unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    fill_addr_d  = fill_addr_q;
    mem_we_d     = mem_we_q;
    mem_re_d     = mem_re_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    phase_timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_data_ready;
`else
    phase_timeout = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          fill_d      = req_fill;
          fill_addr_d = req_fill_addr & LINE_MASK;
          if (req_writeback) begin
            state_d     = S_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_wb_addr & LINE_MASK;
            mem_wdata_d = req_wb_data;
          end else if (req_fill) begin
            state_d    = S_RD;
            mem_re_d   = 1'b1;
            mem_addr_d = req_fill_addr & LINE_MASK;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
          end
        end
      end
      S_WB: begin
        // Write acknowledge hands straight over to the read: no idle cycle between phases.
        if (mem_data_ready && fill_q) begin
          state_d    = S_RD;
          mem_we_d   = 1'b0;
          mem_re_d   = 1'b1;
          mem_addr_d = fill_addr_q;
        end else if (mem_data_ready || phase_timeout) begin
          state_d      = S_RESP;
          mem_we_d     = 1'b0;
          resp_valid_d = 1'b1;
        end
      end
      S_RD: begin
        if (mem_data_ready) begin
          state_d      = S_RESP;
          mem_re_d     = 1'b0;
          resp_data_d  = mem_data_out;
          resp_valid_d = 1'b1;
        end else if (phase_timeout) begin
          state_d      = S_RESP;
          mem_re_d     = 1'b0;
          resp_valid_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef MEM_REQ_TIMEOUT_EN
    resp_error_d = phase_timeout && (state_q == S_WB || state_q == S_RD);
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if ((state_q == S_WB || state_q == S_RD) && !mem_data_ready)
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    else
      wait_cnt_d = wait_cnt_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fill_q       <= 1'b0;
      fill_addr_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
      wait_cnt_q   <= '0;
      resp_error_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      fill_addr_q  <= fill_addr_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
`ifdef MEM_REQ_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      resp_error_q <= resp_error_d;
`endif
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = resp_valid_q;
  assign resp_data        = resp_data_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_address      = mem_addr_q;
  assign mem_data_in      = mem_wdata_q;
`ifdef MEM_REQ_TIMEOUT_EN
  assign resp_error       = resp_error_q;
`else
  assign resp_error       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - self-checking bench for mem_request_unit with a behavioural line memory
module tb_mem_request_unit;
  localparam int AW = 12;
  localparam int LW = 128;
  localparam int TO = 8;
  localparam logic [AW-1:0] AMASK = 12'hFF0;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_writeback, req_fill;
  logic [AW-1:0] req_wb_addr, req_fill_addr;
  logic [LW-1:0] req_wb_data;
  logic          resp_valid, resp_error;
  logic [LW-1:0] resp_data;
  logic          mem_write_enable, mem_read_enable;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_data_in, mem_data_out;
  logic          mem_data_ready;

  always #5 clk = ~clk;

  mem_request_unit #(.ADDRESS_SIZE(AW), .CACHE_LINE_SIZE(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_writeback(req_writeback), .req_fill(req_fill),
    .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data), .req_fill_addr(req_fill_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready)
  );

  typedef struct {
    logic          wb;
    logic          fill;
    logic [AW-1:0] wb_addr;
    logic [LW-1:0] wb_data;
    logic [AW-1:0] fill_addr;
    logic [LW-1:0] rd_data;
    int            delay;
  } vec_t;

  typedef struct {
    logic [LW-1:0] data;
    logic          err;
    int            cycle;
    int            we_n;
    int            re_n;
  } exp_t;

  exp_t          sb[$];
  vec_t          vecs[6];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            we_n = 0;
  int            re_n = 0;
  int            cur_delay = 0;
  logic [LW-1:0] cur_rd = '0;
  logic [LW-1:0] cur_wb_data = '0;
  logic [AW-1:0] cur_wb_addr = '0;
  logic [AW-1:0] cur_fill_addr = '0;
  logic [LW-1:0] last_fill = '0;
  logic          rdy_model = 1'b0;
  logic          rdy_force = 1'b0;

  assign mem_data_ready = rdy_model | rdy_force;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: acknowledges each enabled phase after cur_delay wait cycles.
  initial begin
    int   pc;
    logic acked;
    pc = 0;
    acked = 1'b0;
    mem_data_out = '0;
    forever begin
      @(negedge clk);
      if (rst || !(mem_write_enable || mem_read_enable)) begin
        pc = 0;
        acked = 1'b0;
        rdy_model = 1'b0;
      end else begin
        if (acked) pc = 0;
        rdy_model = (pc == cur_delay);
        acked = rdy_model;
        mem_data_out = rdy_model ? cur_rd : ~cur_rd;
        pc++;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        we_n = 0;
        re_n = 0;
      end else begin
        check("exclusive_enables", {127'd0, mem_write_enable && mem_read_enable}, '0);
        if (mem_write_enable) begin
          we_n++;
          check("wb_addr", {116'd0, mem_address}, {116'd0, cur_wb_addr & AMASK});
          check("wb_data", mem_data_in, cur_wb_data);
        end
        if (mem_read_enable) begin
          re_n++;
          check("rd_addr", {116'd0, mem_address}, {116'd0, cur_fill_addr & AMASK});
        end
        if (resp_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: resp_valid=1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("resp_data", resp_data, e.data);
            check("resp_error", {127'd0, resp_error}, {127'd0, e.err});
            check("resp_cycle", LW'(cyc), LW'(e.cycle));
            check("wr_cycles", LW'(we_n), LW'(e.we_n));
            check("rd_cycles", LW'(re_n), LW'(e.re_n));
          end
          we_n = 0;
          re_n = 0;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input logic timeout);
    int   n;
    int   lat;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", {127'd0, req_ready}, {127'd0, 1'b1});
    cur_delay = v.delay;
    cur_rd = v.rd_data;
    cur_wb_addr = v.wb_addr;
    cur_wb_data = v.wb_data;
    cur_fill_addr = v.fill_addr;
    req_writeback = v.wb;
    req_fill = v.fill;
    req_wb_addr = v.wb_addr;
    req_wb_data = v.wb_data;
    req_fill_addr = v.fill_addr;
    req_valid = 1'b1;
    if (timeout) begin
      lat = 1 + TO;
      e = '{data: last_fill, err: 1'b1, cycle: cyc + lat,
            we_n: v.wb ? TO : 0, re_n: (!v.wb && v.fill) ? TO : 0};
    end else begin
      lat = 1 + (v.wb ? v.delay + 1 : 0) + (v.fill ? v.delay + 1 : 0);
      if (v.fill) last_fill = v.rd_data;
      e = '{data: last_fill, err: 1'b0, cycle: cyc + lat,
            we_n: v.wb ? v.delay + 1 : 0, re_n: v.fill ? v.delay + 1 : 0};
    end
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL resp_missing: %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv;
    vecs[0] = '{wb: 1'b0, fill: 1'b1, wb_addr: 12'h000, wb_data: '0, fill_addr: 12'h123,
                rd_data: 128'hDEADBEEF_00112233_44556677_8899AABB, delay: 0};
    vecs[1] = '{wb: 1'b1, fill: 1'b1, wb_addr: 12'h040, wb_data: {16{8'hA5}}, fill_addr: 12'h080,
                rd_data: 128'h01234567_89ABCDEF_FEDCBA98_76543210, delay: 3};
    vecs[2] = '{wb: 1'b1, fill: 1'b0, wb_addr: 12'h1FF, wb_data: 128'hCAFEF00D_0BADC0DE_13579BDF_2468ACE0,
                fill_addr: 12'h555, rd_data: 128'h5, delay: 1};
    vecs[3] = '{wb: 1'b0, fill: 1'b0, wb_addr: 12'h3C5, wb_data: 128'h77, fill_addr: 12'h2AA,
                rd_data: 128'h99, delay: 0};
    vecs[4] = '{wb: 1'b0, fill: 1'b1, wb_addr: 12'h000, wb_data: '0, fill_addr: 12'hFFF,
                rd_data: {8{16'h1111}}, delay: 2};
    vecs[5] = '{wb: 1'b1, fill: 1'b1, wb_addr: 12'hABC, wb_data: {4{32'h0F1E2D3C}}, fill_addr: 12'h00F,
                rd_data: {4{32'h89ABCDEF}}, delay: 0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_writeback = 1'b0;
    req_fill = 1'b0;
    req_wb_addr = '0;
    req_wb_data = '0;
    req_fill_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", {127'd0, req_ready}, {127'd0, 1'b1});
    check("rst_resp_valid", {127'd0, resp_valid}, '0);
    check("rst_resp_error", {127'd0, resp_error}, '0);
    check("rst_we", {127'd0, mem_write_enable}, '0);
    check("rst_re", {127'd0, mem_read_enable}, '0);
    check("rst_addr", {116'd0, mem_address}, '0);
    check("rst_data_in", mem_data_in, '0);
    check("rst_resp_data", resp_data, '0);

    for (int i = 0; i < 3; i++) begin
      rdy_force = 1'b1;
      @(negedge clk);
      check("idle_ack_ready", {127'd0, req_ready}, {127'd0, 1'b1});
      check("idle_ack_enables", {126'd0, mem_write_enable, mem_read_enable}, '0);
      check("idle_ack_resp", {127'd0, resp_valid}, '0);
    end
    rdy_force = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], 1'b0);
      drain();
    end

    // Back-to-back requests: the second is offered as soon as the unit returns to idle.
    run_vec(vecs[0], 1'b0);
    run_vec(vecs[3], 1'b0);
    drain();

    // Reset while the refill is stalled: no response may ever follow.
    @(negedge clk);
    cur_delay = 1000;
    cur_fill_addr = 12'h2A7;
    req_writeback = 1'b0;
    req_fill = 1'b1;
    req_fill_addr = 12'h2A7;
    req_valid = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("stall_re", {127'd0, mem_read_enable}, {127'd0, 1'b1});
    rst = 1'b1;
    @(negedge clk);
    check("midrst_enables", {126'd0, mem_write_enable, mem_read_enable}, '0);
    check("midrst_ready", {127'd0, req_ready}, {127'd0, 1'b1});
    check("midrst_resp", {127'd0, resp_valid}, '0);
    check("midrst_resp_data", resp_data, '0);
    req_valid = 1'b0;
    rst = 1'b0;
    last_fill = '0;
    repeat (2) begin
      @(negedge clk);
      check("postrst_ready", {127'd0, req_ready}, {127'd0, 1'b1});
    end
    repeat (8) @(negedge clk);

    run_vec(vecs[3], 1'b0);
    drain();
    run_vec(vecs[5], 1'b0);
    drain();

`ifdef MEM_REQ_TIMEOUT_EN
    tv = vecs[4];
    tv.delay = 1000;
    run_vec(tv, 1'b1);
    drain();
    tv = vecs[1];
    tv.delay = 1000;
    run_vec(tv, 1'b1);
    drain();
    @(negedge clk);
    check("timeout_idle", {127'd0, req_ready}, {127'd0, 1'b1});
`else
    tv = vecs[2];
    run_vec(tv, 1'b0);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_request_unit.md
# mem_request_unit

Cache-side initiator for the cache-line memory port: accepts one miss transaction at a time from a cache controller and performs an optional dirty-line writeback followed by an optional line refill. It drives the memory's write/read enables, address and write data, and waits on the memory's `data_ready` acknowledge. It returns the refilled line to the cache with a single-cycle response pulse. It sits between the L1 cache controllers and the shared line-wide memory.

## Interface
- `ADDRESS_SIZE`, 12, byte-address width
- `CACHE_LINE_SIZE`, 128, line width in bits; multiple of 8; line = CACHE_LINE_SIZE/8 bytes
- `TIMEOUT_CYCLES`, 64, wait limit per memory phase; used only with `MEM_REQ_TIMEOUT_EN`

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  transaction offered
- `req_ready`  out  1  unit idle; transfer on `req_valid && req_ready`
- `req_writeback`  in  1  perform writeback phase
- `req_fill`  in  1  perform refill phase
- `req_wb_addr`  in  ADDRESS_SIZE  victim line address
- `req_wb_data`  in  CACHE_LINE_SIZE  victim line data
- `req_fill_addr`  in  ADDRESS_SIZE  refill line address
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_data`  out  CACHE_LINE_SIZE  refilled line; holds until next refill
- `resp_error`  out  1  valid with `resp_valid`; phase timed out
- `mem_write_enable`  out  1  memory write request
- `mem_read_enable`  out  1  memory read request
- `mem_address`  out  ADDRESS_SIZE  line-aligned byte address
- `mem_data_in`  out  CACHE_LINE_SIZE  write data to memory
- `mem_data_out`  in  CACHE_LINE_SIZE  read data from memory
- `mem_data_ready`  in  1  memory acknowledge for the current phase

## Operation
- States: IDLE, WB, RD, RESP.
- IDLE:
  - `req_ready`=1. On handshake, latch all `req_*` fields.
  - Next state: WB if writeback; else RD if fill; else RESP.
- Addresses are forced line-aligned: low log2(CACHE_LINE_SIZE/8) bits cleared before driving `mem_address`.
- WB:
  - `mem_write_enable`=1, `mem_address`=wb addr, `mem_data_in`=wb data, all held stable.
  - On `mem_data_ready`=1: go to RD if fill, else RESP.
- RD:
  - `mem_read_enable`=1, `mem_address`=fill addr.
  - On `mem_data_ready`=1: capture `mem_data_out` into `resp_data`, go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Enable rules:
  - `mem_write_enable` and `mem_read_enable` are never high together.
  - Both are low outside WB and RD.
  - `mem_data_ready` is ignored outside WB and RD.
- `resp_data` is updated only by a successful RD capture. Writeback-only and empty (neither bit set) transactions leave it unchanged.
- `resp_error`=0 except on the timeout path.

## Timing
- All outputs are registered except `req_ready` (= state==IDLE).
- Reset values:
  - state IDLE, `req_ready`=1.
  - `resp_valid`, `resp_error`, `mem_write_enable`, `mem_read_enable` = 0.
  - `mem_address`, `mem_data_in`, `resp_data` = 0.
- Latency, handshake at cycle N, memory acknowledging in its first enabled cycle:
  - fill-only: RD at N+1, `resp_valid` at N+2.
  - writeback+fill: WB at N+1, RD at N+2, `resp_valid` at N+3.
  - empty transaction: `resp_valid` at N+1.
- Each extra cycle of `mem_data_ready` low extends its phase by one cycle. Enables drop the cycle after the acknowledge is sampled.
- WB→RD back-to-back: write enable low and read enable high in the same edge, so there is no bubble.
- A new request is accepted in the cycle after RESP at the earliest.
- `rst` mid-transaction: at the next edge, all outputs take their reset values and the transaction is abandoned with no response. Requests offered while `rst`=1 are not accepted.

## Configuration
- Macro: `MEM_REQ_TIMEOUT_EN`.
- Defined:
  - A wait counter clears on entry to WB or RD and increments each cycle without acknowledge.
  - If it reaches TIMEOUT_CYCLES-1 with `mem_data_ready` still low, the phase aborts and any remaining phase is skipped.
  - Next cycle: RESP with `resp_error`=1; `resp_data` is unchanged.
- Undefined: no counter; phases wait indefinitely; `resp_error` is tied 0.

## Test plan
- Reset, then idle: all outputs 0 except `req_ready`=1; `mem_data_ready` pulses in IDLE cause no state change.
- Fill-only, addr 0x123, memory acks immediately with 0xDEADBEEF_00112233_44556677_8899AABB:
  - `mem_read_enable` at N+1 with `mem_address`=0x120.
  - `resp_valid` at N+2 with that data; `resp_error`=0.
- Writeback 0x040/data 0xA5…A5 + fill 0x080, write ack delayed 3 cycles:
  - write enable held 4 cycles with stable address/data, then read enable next edge.
  - Never both enables high.
- Writeback-only: `resp_valid` after the ack; `resp_data` retains the prior refill value. Empty request: `resp_valid` at N+1, no memory enable ever raised.
- `rst` asserted during RD wait: the next cycle has enables low, `req_ready`=1, and no `resp_valid` ever follows for that transaction.
- With `MEM_REQ_TIMEOUT_EN`, TIMEOUT_CYCLES=8, memory never acks:
  - read enable high 8 cycles.
  - then `resp_valid`=1, `resp_error`=1.
  - then back to IDLE.
